// File: rtl/ob_rsp_serializer.sv
// Order-book response serializer: captures one 115-bit response and emits it MSB-first as a byte frame.
// Optional trailing XOR checksum byte when OB_RSP_SERIALIZER_CHECKSUM_EN is defined.
module ob_rsp_serializer #(
    parameter int unsigned IDLE_GAP_N = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [114:0] in_rsp,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [7:0]   out_data,
    output logic         out_sof,
    output logic         out_eof,
    input  logic         out_rdy,
    output logic         busy
);

`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd15;
`else
    localparam logic [3:0] LAST_IDX = 4'd14;
`endif
    localparam logic [3:0] GAP_INIT = (IDLE_GAP_N == 0) ? 4'd0 : 4'(IDLE_GAP_N - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     gap_q, gap_d;
    logic [114:0]   buf_q, buf_d;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    logic [119:0]   frame;
    logic [7:0]     byte_sel;
    logic           last_acc;
    logic           take;

    // Header nibble A, reserved 0, status; then uid and raw result bytes.
    assign frame = {4'hA, 1'b0, buf_q[82:80], buf_q[114:83], buf_q[79:0]};

    always_comb begin
        byte_sel = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (cnt_q == 4'(i)) byte_sel = frame[8*(14-i) +: 8];
        end
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
        if (cnt_q == 4'd15) byte_sel = csum_q;
`endif
    end

    assign last_acc = (state_q == SEND) && out_rdy && (cnt_q == LAST_IDX);
    assign in_rdy   = rst_n && ((state_q == IDLE) || ((IDLE_GAP_N == 0) && last_acc));
    assign take     = in_vld && in_rdy;

    assign out_vld  = (state_q == SEND);
    assign out_data = out_vld ? byte_sel : '0;
    assign out_sof  = out_vld && (cnt_q == 4'd0);
    assign out_eof  = out_vld && (cnt_q == LAST_IDX);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        buf_d   = buf_q;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    buf_d   = in_rsp;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            SEND: begin
                if (out_rdy) begin
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_sel;
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        // With no gap the final byte doubles as the capture slot for the next frame.
                        if (IDLE_GAP_N == 0) begin
                            if (take) begin
                                state_d = SEND;
                                buf_d   = in_rsp;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
                                csum_d  = '0;
`endif
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_INIT;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_ob_rsp_serializer.sv
// Directed bench for ob_rsp_serializer: one instance with no inter-frame gap, one with a 3-cycle gap.
module tb_ob_rsp_serializer;

`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
    localparam int FL = 16;
`else
    localparam int FL = 15;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [114:0] in_rsp;
    logic         out_rdy;
    logic         in_vld0, in_rdy0, out_vld0, out_sof0, out_eof0, busy0;
    logic [7:0]   out_data0;
    logic         in_vld3, in_rdy3, out_vld3, out_sof3, out_eof3, busy3;
    logic [7:0]   out_data3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ob_rsp_serializer #(.IDLE_GAP_N(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld0), .in_rsp(in_rsp), .in_rdy(in_rdy0),
        .out_vld(out_vld0), .out_data(out_data0), .out_sof(out_sof0), .out_eof(out_eof0),
        .out_rdy(out_rdy), .busy(busy0)
    );

    ob_rsp_serializer #(.IDLE_GAP_N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld3), .in_rsp(in_rsp), .in_rdy(in_rdy3),
        .out_vld(out_vld3), .out_data(out_data3), .out_sof(out_sof3), .out_eof(out_eof3),
        .out_rdy(out_rdy), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor for the gap-0 instance: accepted bytes, flags, stall stability, longest valid run.
    logic [7:0] q_data[$];
    logic       q_sof[$], q_eof[$], q_rdy[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_sof, prev_eof;
    int         run0 = 0, maxrun0 = 0;

    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            chk("stall_vld", {31'd0, out_vld0}, 32'd1);
            chk("stall_data", {24'd0, out_data0}, {24'd0, prev_data});
            chk("stall_flags", {30'd0, out_sof0, out_eof0}, {30'd0, prev_sof, prev_eof});
        end
        prev_stall = out_vld0 && !out_rdy;
        prev_data  = out_data0;
        prev_sof   = out_sof0;
        prev_eof   = out_eof0;
        if (out_vld0 && out_rdy) begin
            q_data.push_back(out_data0);
            q_sof.push_back(out_sof0);
            q_eof.push_back(out_eof0);
            q_rdy.push_back(in_rdy0);
        end
        if (out_vld0) run0++;
        else          run0 = 0;
        if (run0 > maxrun0) maxrun0 = run0;
    end

    // Monitor for the gap-3 instance: bytes, frames, idle spacing between frames.
    int cyc3 = 0, bytes3 = 0, frames3 = 0, gapcyc3 = 0;
    int eof1_cyc = -1, sof2_cyc = -1, gap_at_sof2 = -1;

    always @(negedge clk) begin
        cyc3++;
        if (busy3 && !out_vld3) gapcyc3++;
        if (out_vld3 && out_rdy) begin
            bytes3++;
            if (out_sof3 && frames3 == 1 && sof2_cyc < 0) begin
                sof2_cyc    = cyc3;
                gap_at_sof2 = gapcyc3;
            end
            if (out_eof3) begin
                if (frames3 == 0) eof1_cyc = cyc3;
                frames3++;
            end
        end
    end

    function automatic logic [114:0] mk(input logic [31:0] uid, input logic [2:0] st, input logic [79:0] res);
        return {uid, st, res};
    endfunction

    task automatic send0(input logic [114:0] r);
        logic got;
        got = 1'b0;
        in_rsp  = r;
        in_vld0 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_rdy0) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_vld0 = 1'b0;
        chk("send0_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic send3(input logic [114:0] r);
        logic got;
        got = 1'b0;
        in_rsp  = r;
        in_vld3 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_rdy3) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_vld3 = 1'b0;
        chk("send3_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_q(input int n);
        for (int k = 0; k < 600; k++) begin
            if (q_data.size() >= n) break;
            @(posedge clk); #2;
        end
        chk("wait_bytes", {31'd0, q_data.size() >= n}, 32'd1);
    endtask

    // exp holds the 15 hand-computed frame bytes, byte 0 in the top 8 bits.
    task automatic check_frame(input string tag, input logic [119:0] exp, input int base, input logic chk_rdy);
        logic [7:0] x, e;
        x = '0;
        for (int i = 0; i < 15; i++) begin
            e = exp[119 - 8*i -: 8];
            x = x ^ e;
            if (base + i < q_data.size()) begin
                chk({tag, "_byte"}, {24'd0, q_data[base+i]}, {24'd0, e});
                chk({tag, "_sof"}, {31'd0, q_sof[base+i]}, {31'd0, i == 0});
                chk({tag, "_eof"}, {31'd0, q_eof[base+i]}, {31'd0, i == FL - 1});
                if (chk_rdy) chk({tag, "_inrdy"}, {31'd0, q_rdy[base+i]}, {31'd0, i == FL - 1});
            end else begin
                chk({tag, "_missing"}, base + i, q_data.size());
            end
        end
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
        if (base + 15 < q_data.size()) begin
            chk({tag, "_csum"}, {24'd0, q_data[base+15]}, {24'd0, x});
            chk({tag, "_csum_eof"}, {31'd0, q_eof[base+15]}, 32'd1);
        end else begin
            chk({tag, "_csum_missing"}, base + 15, q_data.size());
        end
`endif
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_eof.delete();
        q_rdy.delete();
    endtask

    localparam logic [119:0] EXP1 = 120'hA0_00001234_00000000000000000000;
    localparam logic [119:0] EXP2 = 120'hA1_DEADBEEF_00000001_00000002_0064;
    localparam logic [119:0] EXP3 = 120'hA2_01234567_0102030405060708090A;
    localparam logic [119:0] EXP4 = 120'hA5_CAFEF00D_FFEEDDCCBBAA99887766;

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n   = 1'b0;
        in_vld0 = 1'b0;
        in_vld3 = 1'b0;
        in_rsp  = '0;
        out_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inrdy_low", {31'd0, in_rdy0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_vld", {31'd0, out_vld0}, 32'd0);
        chk("rst_out_data", {24'd0, out_data0}, 32'd0);
        chk("rst_flags", {30'd0, out_sof0, out_eof0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_inrdy_idle", {31'd0, in_rdy0}, 32'd1);

        // Single frame, zero result
        clear_q();
        send0(mk(32'h0000_1234, 3'd0, 80'h0));
        chk("lat_sof_first", {31'd0, out_vld0 && out_sof0}, 32'd1);
        wait_q(FL);
        check_frame("f1", EXP1, 0, 1'b1);
`ifdef OB_RSP_SERIALIZER_CHECKSUM_EN
        if (q_data.size() >= 16) chk("f1_csum86", {24'd0, q_data[15]}, 32'h86);
`endif
        repeat (3) @(posedge clk); #1;
        chk("f1_idle_after", {31'd0, busy0}, 32'd0);

        // Trade result
        clear_q();
        send0(mk(32'hDEAD_BEEF, 3'd1, {32'h1, 32'h2, 16'h0064}));
        wait_q(FL);
        check_frame("f2", EXP2, 0, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Backpressure 1,0,0,1
        clear_q();
        send0(mk(32'h0123_4567, 3'd2, 80'h0102030405060708090A));
        for (int k = 0; k < 400; k++) begin
            if (q_data.size() >= FL) break;
            out_rdy = pat[k % 4];
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("bp_count", q_data.size(), FL);
        check_frame("bp", EXP3, 0, 1'b0);

        // Back-to-back, no gap
        clear_q();
        maxrun0 = 0;
        send0(mk(32'hDEAD_BEEF, 3'd1, {32'h1, 32'h2, 16'h0064}));
        send0(mk(32'hCAFE_F00D, 3'd5, 80'hFFEEDDCCBBAA99887766));
        wait_q(2*FL);
        repeat (3) @(posedge clk); #1;
        check_frame("b2b_a", EXP2, 0, 1'b0);
        check_frame("b2b_b", EXP4, FL, 1'b0);
        chk("b2b_run", maxrun0, 2*FL);

        // Gap of 3 on second instance
        send3(mk(32'h0000_1234, 3'd0, 80'h0));
        send3(mk(32'hDEAD_BEEF, 3'd1, {32'h1, 32'h2, 16'h0064}));
        for (int k = 0; k < 300; k++) begin
            if (frames3 >= 2) break;
            @(posedge clk); #1;
        end
        chk("gap_frames", frames3, 2);
        chk("gap_bytes", bytes3, 2*FL);
        chk("gap_busy_cycles", gap_at_sof2, 3);
        chk("gap_spacing", sof2_cyc - eof1_cyc, 5);

        // Reset mid-frame
        repeat (5) @(posedge clk); #1;
        clear_q();
        send0(mk(32'h0123_4567, 3'd2, 80'h0102030405060708090A));
        wait_q(7);
        rst_n = 1'b0;
        #1;
        chk("midrst_inrdy", {31'd0, in_rdy0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_vld", {31'd0, out_vld0}, 32'd0);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        repeat (4) @(posedge clk); #1;
        chk("midrst_no_more", {31'd0, out_vld0}, 32'd0);
        clear_q();
        send0(mk(32'hCAFE_F00D, 3'd5, 80'hFFEEDDCCBBAA99887766));
        wait_q(FL);
        check_frame("postrst", EXP4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
